// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: write-port controller for the 32x32 MIPS register file.
// Two writeback requesters (A = ALU, B = load) are arbitrated round-robin onto
// a small in-order FIFO that drains one write per cycle through registered
// Awr/Din/WrEn outputs. Pend1/Pend2 flag decode hazards against queued and
// in-flight writes.
// Optional feature macro: REGFILE_CLEAR_EN -- after reset, zero R1..R31 with 31
// back-to-back writes before accepting requests (Busy high meanwhile).
//
// Handshake: a requester raises Req with Awr/Din and holds all three stable
// until it sees Ack high in a cycle; that cycle's values are taken at the next
// rising edge, and the requester may drop or change its request afterwards.
module regfile_wr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqA,
    input  logic [4:0]  AwrA,
    input  logic [31:0] DinA,
    output logic        AckA,
    input  logic        ReqB,
    input  logic [4:0]  AwrB,
    input  logic [31:0] DinB,
    output logic        AckB,
    input  logic [4:0]  Adr1,
    input  logic [4:0]  Adr2,
    output logic        Pend1,
    output logic        Pend2,
    output logic [4:0]  Awr,
    output logic [31:0] Din,
    output logic        WrEn,
    output logic        Full,
    output logic        Busy,
    output logic        state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic { S_CLEAR = 1'b0, S_RUN = 1'b1 } state_t;
    typedef enum logic { GRANT_A = 1'b0, GRANT_B = 1'b1 } grant_t;

    state_t          state;
    grant_t          last_grant;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [4:0]      mem_awr [DEPTH];
    logic [31:0]     mem_din [DEPTH];
    logic            eligible;
    logic            push;
    logic            pop;
    logic [4:0]      push_awr;
    logic [31:0]     push_din;

`ifdef REGFILE_CLEAR_EN
    state_t          state_next;
    logic [4:0]      clr_idx;

    // Sequencer state register: CLEAR after reset, RUN once R31 is issued.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_CLEAR;
        else       state <= state_next;
    end

    // Next-state logic: leave CLEAR in the cycle that issues the R31 write.
    always_comb begin
        state_next = state;
        if (state == S_CLEAR && clr_idx == 5'd31) state_next = S_RUN;
    end

    // Clear address counter walks R1..R31 while in CLEAR.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                 clr_idx <= 5'd1;
        else if (state == S_CLEAR) clr_idx <= clr_idx + 5'd1;
    end

    assign Busy = (state == S_CLEAR);
`else
    assign state = S_RUN;
    assign Busy  = 1'b0;
`endif

    assign state_dbg = state;
    assign Full      = (count == CW'(DEPTH));
    assign pop       = (count != '0);

    // Requests are only taken in RUN with room in the FIFO; a same-cycle pop
    // does not count as room. Reset forces both acks low.
    assign eligible  = (state == S_RUN) && !Full && !Reset;

    // Round-robin arbitration: on a tie the requester not granted last wins.
    always_comb begin
        AckA = 1'b0;
        AckB = 1'b0;
        if (eligible) begin
            if (ReqA && ReqB) begin
                if (last_grant == GRANT_B) AckA = 1'b1;
                else                       AckB = 1'b1;
            end else if (ReqA) begin
                AckA = 1'b1;
            end else if (ReqB) begin
                AckB = 1'b1;
            end
        end
    end

    assign push_awr = AckA ? AwrA : AwrB;
    assign push_din = AckA ? DinA : DinB;
    // Writes to R0 are acked but dropped so R0 is never written.
    assign push     = (AckA || AckB) && (push_awr != 5'd0);

    // Remember who won last, including R0 grants.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)     last_grant <= GRANT_B;
        else if (AckA) last_grant <= GRANT_A;
        else if (AckB) last_grant <= GRANT_B;
    end

    // FIFO storage; contents need no reset because validity comes from count.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_awr[wr_ptr] <= push_awr;
            mem_din[wr_ptr] <= push_din;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port: clear writes, then one FIFO pop per cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Awr  <= 5'd0;
            Din  <= 32'd0;
            WrEn <= 1'b0;
        end else begin
`ifdef REGFILE_CLEAR_EN
            if (state == S_CLEAR) begin
                Awr  <= clr_idx;
                Din  <= 32'd0;
                WrEn <= 1'b1;
            end else
`endif
            if (pop) begin
                Awr  <= mem_awr[rd_ptr];
                Din  <= mem_din[rd_ptr];
                WrEn <= 1'b1;
            end else begin
                WrEn <= 1'b0;
            end
        end
    end

    // Hazard flags: match against every valid FIFO entry and the in-flight write.
    always_comb begin
        logic [PW-1:0] off;
        Pend1 = 1'b0;
        Pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (CW'(off) < count) begin
                if (mem_awr[i] == Adr1) Pend1 = 1'b1;
                if (mem_awr[i] == Adr2) Pend2 = 1'b1;
            end
        end
        if (WrEn && Awr == Adr1) Pend1 = 1'b1;
        if (WrEn && Awr == Adr2) Pend2 = 1'b1;
        if (Adr1 == 5'd0) Pend1 = 1'b0;
        if (Adr2 == 5'd0) Pend2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed testbench for regfile_wr_ctrl. Inputs change just after the falling
// edge; outputs are checked there too, away from the rising (active) edge.
module tb_regfile_wr_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqA, ReqB;
    logic [4:0]  AwrA, AwrB, Adr1, Adr2;
    logic [31:0] DinA, DinB;
    logic        AckA, AckB, Pend1, Pend2;
    logic [4:0]  Awr;
    logic [31:0] Din;
    logic        WrEn, Full, Busy, state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    logic [36:0] exp_q[$];
    logic [36:0] got_q[$];
    logic [31:0] rf [32];

    regfile_wr_ctrl #(.DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqA(ReqA), .AwrA(AwrA), .DinA(DinA), .AckA(AckA),
        .ReqB(ReqB), .AwrB(AwrB), .DinB(DinB), .AckB(AckB),
        .Adr1(Adr1), .Adr2(Adr2), .Pend1(Pend1), .Pend2(Pend2),
        .Awr(Awr), .Din(Din), .WrEn(WrEn), .Full(Full), .Busy(Busy),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 Clk = ~Clk;

    // Register file model and write log, capturing like the real array does.
    always @(posedge Clk) begin
        if (!Reset && WrEn) begin
            got_q.push_back({Awr, Din});
            if (Awr != 5'd0) rf[Awr] = Din;
        end
    end

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; ReqA = 1'b1; ReqB = 1'b0;
        AwrA = 5'd3; DinA = 32'h3; AwrB = 5'd0; DinB = 32'h0;
        Adr1 = 5'd3; Adr2 = 5'd0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'hDEADBEEF;
        idle(2);
        n_cmp++; if (Awr !== 5'd0)  begin n_err++; $display("FAIL reset_awr: got %0h want 0", Awr); end
        n_cmp++; if (Din !== 32'd0) begin n_err++; $display("FAIL reset_din: got %0h want 0", Din); end
        n_cmp++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %0b want 0", WrEn); end
        n_cmp++; if (Full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b want 0", Full); end
        n_cmp++; if (AckA !== 1'b0) begin n_err++; $display("FAIL reset_acka: got %0b want 0", AckA); end
        n_cmp++; if (Pend1 !== 1'b0) begin n_err++; $display("FAIL reset_pend1: got %0b want 0", Pend1); end
`ifdef REGFILE_CLEAR_EN
        n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %0b want 1", Busy); end
`else
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", Busy); end
`endif
        ReqA = 1'b0; Adr1 = 5'd0;
        Reset = 1'b0;
    endtask

`ifdef REGFILE_CLEAR_EN
    task automatic test_clear();
        int n = 0;
        int ack_during_busy = 0;
        ReqA = 1'b1; AwrA = 5'd7; DinA = 32'h77;
        #1;
        while (Busy && n < 40) begin
            if (AckA) ack_during_busy++;
            n++;
            cyc(); #1;
        end
        n_cmp++; if (n !== 31) begin n_err++; $display("FAIL clear_busy_len: got %0d want 31", n); end
        n_cmp++; if (ack_during_busy !== 0) begin n_err++; $display("FAIL clear_ack_busy: got %0d want 0", ack_during_busy); end
        n_cmp++; if (AckA !== 1'b1) begin n_err++; $display("FAIL clear_first_ack: got %0b want 1", AckA); end
        n_cmp++; if ({WrEn, Awr} !== {1'b1, 5'd31}) begin n_err++; $display("FAIL clear_last: got %0h want 3f", {WrEn, Awr}); end
        cyc(); ReqA = 1'b0;
        idle(3);
        for (int i = 1; i < 32; i++) exp_q.push_back({5'(i), 32'h0});
        exp_q.push_back({5'd7, 32'h77});
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL clear_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL clear_write: got %0h want %0h", got_q[0], exp_q[0]); end
            void'(got_q.pop_front()); void'(exp_q.pop_front());
        end
        for (int i = 1; i < 32; i++) begin
            n_cmp++; if (rf[i] !== ((i == 7) ? 32'h77 : 32'h0)) begin n_err++; $display("FAIL clear_rf%0d: got %0h", i, rf[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask
`endif

    task automatic test_single();
        ReqA = 1'b1; AwrA = 5'd1; DinA = 32'h1;
        #1;
        n_cmp++; if ({AckA, AckB} !== 2'b10) begin n_err++; $display("FAIL single_ack: got %0b want 10", {AckA, AckB}); end
        cyc(); ReqA = 1'b0;
        n_cmp++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL single_wren_k: got %0b want 0", WrEn); end
        cyc();
        n_cmp++; if ({WrEn, Awr, Din} !== {1'b1, 5'd1, 32'h1}) begin n_err++; $display("FAIL single_out: got %0h want %0h", {WrEn, Awr, Din}, {1'b1, 5'd1, 32'h1}); end
        cyc();
        n_cmp++; if (rf[1] !== 32'h1) begin n_err++; $display("FAIL single_rf1: got %0h want 1", rf[1]); end
        n_cmp++; if ({WrEn, Awr, Din} !== {1'b0, 5'd1, 32'h1}) begin n_err++; $display("FAIL single_hold: got %0h want %0h", {WrEn, Awr, Din}, {1'b0, 5'd1, 32'h1}); end
        n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_r0();
        ReqB = 1'b1; AwrB = 5'd0; DinB = 32'hFFFFFFFF; Adr1 = 5'd0;
        #1;
        n_cmp++; if ({AckA, AckB} !== 2'b01) begin n_err++; $display("FAIL r0_ack: got %0b want 01", {AckA, AckB}); end
        n_cmp++; if (Pend1 !== 1'b0) begin n_err++; $display("FAIL r0_pend1: got %0b want 0", Pend1); end
        cyc(); ReqB = 1'b0;
        n_cmp++; if (Pend1 !== 1'b0) begin n_err++; $display("FAIL r0_pend1_after: got %0b want 0", Pend1); end
        cyc();
        n_cmp++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL r0_wren: got %0b want 0", WrEn); end
        idle(2);
        n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL r0_writes: got %0d want 0", got_q.size()); end
        n_cmp++; if (rf[0] !== 32'h0) begin n_err++; $display("FAIL r0_rf0: got %0h want 0", rf[0]); end
    endtask

    task automatic test_tie();
        logic [1:0] want;
        ReqA = 1'b1; AwrA = 5'd2; DinA = 32'hA;
        ReqB = 1'b1; AwrB = 5'd3; DinB = 32'hB;
        #1;
        n_cmp++; if ({AckA, AckB} !== 2'b10) begin n_err++; $display("FAIL tie_first: got %0b want 10", {AckA, AckB}); end
        cyc(); ReqA = 1'b0;
        #1;
        n_cmp++; if ({AckA, AckB} !== 2'b01) begin n_err++; $display("FAIL tie_second: got %0b want 01", {AckA, AckB}); end
        cyc(); ReqB = 1'b0;
        exp_q.push_back({5'd2, 32'hA});
        exp_q.push_back({5'd3, 32'hB});
        // Both held for four cycles: grants alternate A,B,A,B.
        for (int i = 0; i < 4; i++) begin
            ReqA = 1'b1; AwrA = 5'd10; DinA = 32'hA0 + 32'(i);
            ReqB = 1'b1; AwrB = 5'd11; DinB = 32'hB0 + 32'(i);
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            n_cmp++; if ({AckA, AckB} !== want) begin n_err++; $display("FAIL tie_alt%0d: got %0b want %0b", i, {AckA, AckB}, want); end
            if (i % 2 == 0) exp_q.push_back({5'd10, 32'hA0 + 32'(i)});
            else            exp_q.push_back({5'd11, 32'hB0 + 32'(i)});
            cyc();
        end
        ReqA = 1'b0; ReqB = 1'b0;
        idle(3);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL tie_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL tie_order: got %0h want %0h", got_q[0], exp_q[0]); end
            void'(got_q.pop_front()); void'(exp_q.pop_front());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int cycles = 0;
        // With one pop per cycle the FIFO never holds more than one entry,
        // so every cycle of a held request is acked and Full stays low.
        while (sent < 6 && cycles < 20) begin
            ReqA = 1'b1; AwrA = 5'(sent + 1); DinA = 32'h100 + 32'(sent);
            #1;
            n_cmp++; if ({AckA, Full} !== 2'b10) begin n_err++; $display("FAIL b2b_ack%0d: got %0b want 10", sent, {AckA, Full}); end
            if (AckA) begin
                exp_q.push_back({5'(sent + 1), 32'h100 + 32'(sent)});
                sent++;
            end
            cycles++;
            cyc();
        end
        ReqA = 1'b0;
        n_cmp++; if (sent !== 6) begin n_err++; $display("FAIL b2b_sent: got %0d want 6", sent); end
        idle(3);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL b2b_order: got %0h want %0h", got_q[0], exp_q[0]); end
            void'(got_q.pop_front()); void'(exp_q.pop_front());
        end
        for (int i = 1; i <= 6; i++) begin
            n_cmp++; if (rf[i] !== 32'h100 + 32'(i - 1)) begin n_err++; $display("FAIL b2b_rf%0d: got %0h", i, rf[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_hazard();
        ReqA = 1'b1; AwrA = 5'd5; DinA = 32'h55; Adr1 = 5'd5; Adr2 = 5'd6;
        #1;
        n_cmp++; if ({AckA, Pend1, Pend2} !== 3'b100) begin n_err++; $display("FAIL hz_ack: got %0b want 100", {AckA, Pend1, Pend2}); end
        cyc(); ReqA = 1'b0;
        n_cmp++; if ({WrEn, Pend1, Pend2} !== 3'b010) begin n_err++; $display("FAIL hz_queued: got %0b want 010", {WrEn, Pend1, Pend2}); end
        cyc();
        n_cmp++; if ({WrEn, Awr, Pend1, Pend2} !== {1'b1, 5'd5, 2'b10}) begin n_err++; $display("FAIL hz_inflight: got %0h want %0h", {WrEn, Awr, Pend1, Pend2}, {1'b1, 5'd5, 2'b10}); end
        Adr1 = 5'd0; Adr2 = 5'd5;
        #1;
        n_cmp++; if ({Pend1, Pend2} !== 2'b01) begin n_err++; $display("FAIL hz_swap: got %0b want 01", {Pend1, Pend2}); end
        Adr1 = 5'd5; Adr2 = 5'd6;
        cyc();
        n_cmp++; if ({WrEn, Pend1, Pend2} !== 3'b000) begin n_err++; $display("FAIL hz_done: got %0b want 000", {WrEn, Pend1, Pend2}); end
        n_cmp++; if (rf[5] !== 32'h55) begin n_err++; $display("FAIL hz_rf5: got %0h want 55", rf[5]); end
        Adr1 = 5'd0; Adr2 = 5'd0;
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            ReqA = 1'b1; AwrA = 5'(7 + i); DinA = 32'h70 + 32'(i);
            #1;
            n_cmp++; if (AckA !== 1'b1) begin n_err++; $display("FAIL rst_ack%0d: got %0b want 1", i, AckA); end
            cyc();
        end
        ReqA = 1'b0; Adr1 = 5'd9; Adr2 = 5'd8;
        #1;
        n_cmp++; if ({Pend1, Pend2, WrEn} !== 3'b111) begin n_err++; $display("FAIL rst_pre: got %0b want 111", {Pend1, Pend2, WrEn}); end
        Reset = 1'b1;
        #1;
        n_cmp++; if ({WrEn, Pend1, Pend2, Full} !== 4'b0000) begin n_err++; $display("FAIL rst_async: got %0b want 0000", {WrEn, Pend1, Pend2, Full}); end
        n_cmp++; if (Awr !== 5'd0) begin n_err++; $display("FAIL rst_awr: got %0h want 0", Awr); end
        idle(2);
        Reset = 1'b0;
`ifdef REGFILE_CLEAR_EN
        while (Busy && n < 40) begin cyc(); n++; end
        n_cmp++; if (n !== 31) begin n_err++; $display("FAIL rst_reclear: got %0d want 31", n); end
        idle(4);
        n_cmp++; if (got_q.size() !== 32) begin n_err++; $display("FAIL rst_count: got %0d want 32", got_q.size()); end
`else
        idle(5);
        n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL rst_count: got %0d want 1", got_q.size()); end
`endif
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== {5'd7, 32'h70}) begin n_err++; $display("FAIL rst_first: got %0h want %0h", got_q[0], {5'd7, 32'h70}); end
        end
        Adr1 = 5'd0; Adr2 = 5'd0;
        got_q.delete();
    endtask

    initial begin
        test_reset();
`ifdef REGFILE_CLEAR_EN
        test_clear();
`else
        #1;
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL run_busy: got %0b want 0", Busy); end
`endif
        test_single();
        test_r0();
        test_tie();
        test_back_to_back();
        test_hazard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
